// File: rtl/zap_sync_edge_filter.sv
// Per-bit stability filter for pre-synchronized inputs. Generates registered edge
// pulses and sticky pending flags with enable gating, and ORs the flags into o_irq.
module zap_sync_edge_filter #(
    parameter int unsigned WIDTH         = 32'd1,
    parameter int unsigned FILTER_CYCLES = 32'd4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_sync,
    input  logic [WIDTH-1:0] i_rise_en,
    input  logic [WIDTH-1:0] i_fall_en,
    input  logic [WIDTH-1:0] i_clear,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic [WIDTH-1:0] o_pending,
    output logic             o_irq
);

    localparam int unsigned     CNT_W   = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

    generate
        if (FILTER_CYCLES < 1 || FILTER_CYCLES > 65535) begin : g_bad_filter_cycles
            $error("zap_sync_edge_filter: FILTER_CYCLES must be in 1..65535");
        end
    endgenerate

    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        cnt_d   = cnt_q;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            if (i_sync[b] == level_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == CNT_MAX) begin
                level_d[b] = i_sync[b];
                cnt_d[b]   = '0;
                rise_d[b]  = i_sync[b];
                fall_d[b]  = ~i_sync[b];
            end else begin
                cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
        end
        // A capture on this edge wins over a coincident write-1-to-clear.
        pending_d = (pending_q & ~i_clear) | (rise_d & i_rise_en) | (fall_d & i_fall_en);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            level_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            pending_q <= '0;
            for (int unsigned b = 0; b < WIDTH; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            level_q   <= level_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            pending_q <= pending_d;
            for (int unsigned b = 0; b < WIDTH; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    assign o_level   = level_q;
    assign o_rise    = rise_q;
    assign o_fall    = fall_q;
    assign o_pending = pending_q;
    assign o_irq     = |pending_q;

endmodule
